// File: rtl/push_button_pkg.sv
// Shared FSM state encoding and default cycle counts for the push-button debouncer.
package push_button_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } pb_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES   = 1000000;
  localparam int unsigned DEF_LONG_PRESS_CYCLES = 50000000;
  localparam int unsigned DEF_REPEAT_CYCLES     = 10000000;

endpackage

// File: rtl/push_button_debounce_if.sv
// Button-side signal bundle; master drives the raw button, slave is the debouncer.
// o_long_press exists only when PUSH_BUTTON_LONG_PRESS_EN is defined.
interface push_button_debounce_if;
  logic i_push_button_n;
  logic o_button_n;
  logic o_press_pulse;
  logic o_release_pulse;
`ifdef PUSH_BUTTON_LONG_PRESS_EN
  logic o_long_press;

  modport master (output i_push_button_n,
                  input  o_button_n, input o_press_pulse, input o_release_pulse,
                  input  o_long_press);
  modport slave  (input  i_push_button_n,
                  output o_button_n, output o_press_pulse, output o_release_pulse,
                  output o_long_press);
`else
  modport master (output i_push_button_n,
                  input  o_button_n, input o_press_pulse, input o_release_pulse);
  modport slave  (input  i_push_button_n,
                  output o_button_n, output o_press_pulse, output o_release_pulse);
`endif
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; 2-cycle latency, reset value parameterised.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/push_button_debounce.sv
// Debounces an active-low push button; level/pulses change DEBOUNCE_CYCLES+2 cycles after a stable raw edge.
// PUSH_BUTTON_LONG_PRESS_EN adds a hold counter driving o_long_press (first event, then auto-repeat).
module push_button_debounce
  import push_button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
  parameter int unsigned REPEAT_CYCLES     = DEF_REPEAT_CYCLES
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  push_button_debounce_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // The sample that leaves a stable state is the first of the run, so the
  // wait state accepts after DEBOUNCE_CYCLES-1 further samples.
  localparam logic [CNT_W-1:0] ACCEPT_CNT = CNT_W'(DEBOUNCE_CYCLES - 2);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 1 || REPEAT_CYCLES > LONG_PRESS_CYCLES) begin : g_bad_cfg
    $error("push_button_debounce: unsupported cycle-count parameters");
  end

  logic             sync;
  pb_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             button_q, button_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (bus.i_push_button_n),
    .o_q     (sync)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_RELEASED;
      cnt_q     <= '0;
      button_q  <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      button_q  <= button_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    button_d  = button_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      ST_RELEASED: begin
        if (!sync) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (sync) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == ACCEPT_CNT) begin
          state_d  = ST_PRESSED;
          cnt_d    = '0;
          button_d = 1'b0;
          press_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PRESSED: begin
        if (sync) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (!sync) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == ACCEPT_CNT) begin
          state_d   = ST_RELEASED;
          cnt_d     = '0;
          button_d  = 1'b1;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.o_button_n      = button_q;
  assign bus.o_press_pulse   = press_q;
  assign bus.o_release_pulse = release_q;

`ifdef PUSH_BUTTON_LONG_PRESS_EN
  localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [HOLD_W-1:0] LONG_T   = HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] REPEAT_T = HOLD_W'(REPEAT_CYCLES);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [HOLD_W-1:0] hold_inc;
  logic              seen_q, seen_d;
  logic              long_q, long_d;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      hold_q <= '0;
      seen_q <= 1'b0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      seen_q <= seen_d;
      long_q <= long_d;
    end
  end

  // One counter serves both the initial long-press interval and the repeat period.
  always_comb begin
    hold_d   = hold_q;
    seen_d   = seen_q;
    long_d   = 1'b0;
    hold_inc = hold_q + 1'b1;
    if (state_d == ST_RELEASED) begin
      hold_d = '0;
      seen_d = 1'b0;
    end else if (state_q == ST_PRESSED && state_d == ST_PRESSED) begin
      if (hold_inc == (seen_q ? REPEAT_T : LONG_T)) begin
        hold_d = '0;
        seen_d = 1'b1;
        long_d = 1'b1;
      end else begin
        hold_d = hold_inc;
      end
    end
  end

  assign bus.o_long_press = long_q;
`endif

endmodule

// File: doc/push_button_debounce.md
PUSH_BUTTON_DEBOUNCE -- requirements
Module: push_button_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable synchronized samples required to accept a new level (min 2).
REQ-002 SHALL have parameter LONG_PRESS_CYCLES, default 50000000: held-press cycles, counted from accepted press, before first long-press event.
REQ-003 SHALL have parameter REPEAT_CYCLES, default 10000000: cycles between auto-repeat events while held after long press.
REQ-004 SHALL have port i_clk  input  1  rising-edge clock.
REQ-005 SHALL have port i_reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_push_button_n  input  1  raw asynchronous push button, active-low, bouncing.
REQ-007 SHALL have port o_button_n  output  1  debounced level, active-low; drives the downstream latch push-button input directly.
REQ-008 SHALL have port o_press_pulse  output  1  one-cycle pulse on accepted press.
REQ-009 SHALL have port o_release_pulse  output  1  one-cycle pulse on accepted release.
REQ-010 SHALL have port o_long_press  output  1  one-cycle pulse on long press and each auto-repeat (present only with macro, REQ-030).

Function
REQ-011 SHALL pass i_push_button_n through a two-flop synchronizer; all logic uses the second flop output (sync).
REQ-012 SHALL implement FSM states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-013 RELEASED: sync=0 -> PRESS_WAIT with counter cleared; else stay.
REQ-014 PRESS_WAIT: counter increments each cycle sync=0; sync=1 -> RELEASED, counter cleared (bounce rejected, no pulse).
REQ-015 PRESS_WAIT: when DEBOUNCE_CYCLES consecutive sync=0 samples are seen -> PRESSED; o_button_n falls and o_press_pulse asserts for one cycle in the same cycle.
REQ-016 PRESSED/RELEASE_WAIT mirror REQ-013..015 for sync=1; acceptance -> RELEASED, o_button_n rises, o_release_pulse asserts one cycle.
REQ-017 Total latency raw edge (held stable) to o_button_n change SHALL be exactly DEBOUNCE_CYCLES+2 cycles.
REQ-018 Debounce counter width SHALL be $clog2(DEBOUNCE_CYCLES+1); counter SHALL never wrap (cleared on state change).
REQ-019 o_press_pulse and o_release_pulse SHALL never assert in the same cycle; minimum spacing between them is DEBOUNCE_CYCLES cycles.
REQ-020 Glitch shorter than DEBOUNCE_CYCLES in either stable state SHALL produce no output change.

Reset
REQ-021 On i_reset=1 at a clock edge: state RELEASED, counters 0, synchronizer flops 1, o_button_n=1, all pulse outputs 0.
REQ-022 Reset mid-operation (any state) SHALL abort without emitting any pulse; button held through reset deassertion is treated as new press (full debounce applies).
REQ-023 Reset SHALL take priority over all other events in the same cycle.

Configuration
REQ-030 Macro PUSH_BUTTON_LONG_PRESS_EN SHALL compile in the long-press/auto-repeat counter and o_long_press.
REQ-031 With macro: in PRESSED, hold counter (width $clog2(LONG_PRESS_CYCLES+1)) counts from acceptance; at LONG_PRESS_CYCLES pulse o_long_press, then pulse every REPEAT_CYCLES until leaving PRESSED; counters clear on leaving PRESSED; RELEASE_WAIT freezes counters and a rejected release resumes counting.
REQ-032 Without macro: port o_long_press absent, no hold counter logic; all other behaviour identical.

Structure
REQ-040 Shared package push_button_pkg SHALL hold the FSM state enum typedef and default cycle-count constants.
REQ-041 Sub-module sync_2ff (two-flop synchronizer, reset value parameterised) SHALL be instantiated for REQ-011.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, REPEAT_CYCLES=8)
REQ-050 Clean press held 10 cycles from reset-released idle -> o_button_n falls exactly 6 cycles after raw edge, o_press_pulse one cycle same cycle.
REQ-051 Raw low 3 cycles then high -> o_button_n stays 1, no pulses; retry with 4 stable cycles -> accepted.
REQ-052 Bouncy release (1,0,1,0,1 then stable 1) while pressed -> single o_release_pulse 6 cycles after last 0->1 transition.
REQ-053 Macro on, hold 40 cycles after acceptance -> o_long_press at +20, +28, +36; none after release.
REQ-054 i_reset pulsed while in PRESS_WAIT with raw held low -> no pulse, outputs at reset values, press accepted 6 cycles after reset deasserts.
REQ-055 Macro off build -> elaborates without o_long_press; REQ-050..052 results unchanged.
